// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline datapath and the hazard
// controller.
//   master : datapath side. Drives the decode-stage register fields, branch_E
//            and mem_busy_M. Receives the stall, flush and forward selects and
//            the performance counters.
//   slave  : hazard_ctrl side, with the opposite directions.
// M = register address width, C = performance counter width.
interface hazard_ctrl_if #(
   parameter int M = 4,
   parameter int C = 16
);
   logic [M-1:0] regAD, regBD, regScr_D;
   logic         regw_D, regmem_D, branch_E, mem_busy_M;
   logic         stall_F, stall_D, flush_D, flush_E;
   logic [1:0]   fwdA_E, fwdB_E;
   logic [C-1:0] stall_cnt, lduse_cnt;

   modport master (
      output regAD, regBD, regScr_D, regw_D, regmem_D, branch_E, mem_busy_M,
      input  stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E,
             stall_cnt, lduse_cnt
   );

   modport slave (
      input  regAD, regBD, regScr_D, regw_D, regmem_D, branch_E, mem_busy_M,
      output stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E,
             stall_cnt, lduse_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and forwarding controller for the 5-stage pipeline.
// It keeps a shadow copy of the E/M/W destination and control state and
// advances it in lock-step with the datapath registers. From that state and
// the current decode inputs it produces, combinationally, the stall, flush
// and operand-forward selects. It also keeps saturating counters for stall
// cycles and load-use bubbles.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; clears all shadow state and counters
//   hz  : hazard_ctrl_if.slave (decode fields, branch_E, mem_busy_M in;
//         stall_F/D, flush_D/E, fwdA/B_E, stall_cnt, lduse_cnt out)

// Operand forward select for one execute-stage source.
// 10 = M result, 01 = W result, 00 = register file. M is checked first
// because it holds the newer value.
module hazard_fwd_sel #(
   parameter int M = 4
) (
   input  logic [M-1:0] src_E,
   input  logic [M-1:0] dst_M,
   input  logic         regw_M,
   input  logic [M-1:0] dst_W,
   input  logic         regw_W,
   output logic [1:0]   fwd
);
   always_comb begin
      fwd = 2'b00;
      if (regw_M && (dst_M == src_E))
         fwd = 2'b10;
      else if (regw_W && (dst_W == src_E))
         fwd = 2'b01;
   end
endmodule

module hazard_ctrl #(
   parameter int M = 4,
   parameter int C = 16
) (
   input logic           clk,
   input logic           rst,
   hazard_ctrl_if.slave  hz
);
   typedef struct packed {
      logic [M-1:0] src_a;
      logic [M-1:0] src_b;
      logic [M-1:0] dst;
      logic         regw;
      logic         regmem;
   } e_stage_t;

   typedef struct packed {
      logic [M-1:0] dst;
      logic         regw;
   } wb_stage_t;

   localparam logic [C-1:0] CNT_MAX = '1;

   e_stage_t        e_q;
   wb_stage_t       m_q, w_q;
   logic [C-1:0]    stall_cnt_q, lduse_cnt_q;
   logic            lduse, stall, flush_e, lduse_bubble;
   logic [1:0][M-1:0] src_e;
   logic [1:0][1:0]   fwd;

   // Both sources are always compared, even if the consumer ignores one;
   // a spurious bubble costs a cycle but never corrupts data.
   assign lduse = e_q.regw & e_q.regmem &
                  ((e_q.dst == hz.regAD) | (e_q.dst == hz.regBD));

   // Memory wait freezes everything. A taken branch squashes the consumer,
   // so it overrides the load-use stall.
   assign stall        = hz.mem_busy_M | (lduse & ~hz.branch_E);
   assign flush_e      = (hz.branch_E | lduse) & ~hz.mem_busy_M;
   assign lduse_bubble = lduse & ~hz.branch_E & ~hz.mem_busy_M;

   assign hz.stall_F   = stall;
   assign hz.stall_D   = stall;
   assign hz.flush_D   = hz.branch_E & ~hz.mem_busy_M;
   assign hz.flush_E   = flush_e;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.lduse_cnt = lduse_cnt_q;

   assign src_e[0] = e_q.src_a;
   assign src_e[1] = e_q.src_b;

   generate
      for (genvar op = 0; op < 2; op++) begin : g_fwd
         hazard_fwd_sel #(.M(M)) u_fwd (
            .src_E  (src_e[op]),
            .dst_M  (m_q.dst),
            .regw_M (m_q.regw),
            .dst_W  (w_q.dst),
            .regw_W (w_q.regw),
            .fwd    (fwd[op])
         );
      end
   endgenerate

   assign hz.fwdA_E = fwd[0];
   assign hz.fwdB_E = fwd[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q         <= '0;
         m_q         <= '0;
         w_q         <= '0;
         stall_cnt_q <= '0;
         lduse_cnt_q <= '0;
      end else begin
         if (!hz.mem_busy_M) begin
            w_q <= m_q;
            m_q <= wb_stage_t'{dst: e_q.dst, regw: e_q.regw};
            // A flushed E entry is all zeros, so it can neither forward
            // nor trigger a load-use stall.
            if (flush_e)
               e_q <= '0;
            else
               e_q <= e_stage_t'{src_a:  hz.regAD,
                                 src_b:  hz.regBD,
                                 dst:    hz.regScr_D,
                                 regw:   hz.regw_D,
                                 regmem: hz.regmem_D};
         end
         if (stall && (stall_cnt_q != CNT_MAX))
            stall_cnt_q <= stall_cnt_q + C'(1);
         if (lduse_bubble && (lduse_cnt_q != CNT_MAX))
            lduse_cnt_q <= lduse_cnt_q + C'(1);
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed scenarios plus randomized traffic for
// hazard_ctrl. The reference keeps the in-flight instructions as an array
// (0 = E, 1 = M, 2 = W). Forwarding is taken from the newest matching
// producer, and integer counters are clamped at 2^C-1.
module tb_hazard_ctrl;
   localparam int M    = 4;
   localparam int C    = 4;
   localparam int CMAX = (1 << C) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.M(M), .C(C)) hz ();
   hazard_ctrl #(.M(M), .C(C)) dut (.clk(clk), .rst(rst), .hz(hz));

   typedef struct {
      logic [M-1:0] a, b, d;
      bit           w, ld;
   } ins_t;

   ins_t pipe [3];
   int   m_stall, m_lduse;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic       o_st, o_fd, o_fe;
   logic [1:0] o_fa, o_fb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      m_stall = 0;
      m_lduse = 0;
   endfunction

   // Newest writer of register s among the older stages decides the select.
   function automatic logic [1:0] fwd_of(input logic [M-1:0] s);
      for (int k = 1; k <= 2; k++)
         if (pipe[k].w && pipe[k].d == s) return (k == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   // One clock cycle: drive, check outputs at negedge, advance the model at posedge.
   task automatic cyc(input logic [M-1:0] a, b, d, input bit w, ld, br, busy, r);
      bit   lu, st, fd, fe;
      ins_t nxt;
      hz.regAD = a; hz.regBD = b; hz.regScr_D = d;
      hz.regw_D = w; hz.regmem_D = ld; hz.branch_E = br; hz.mem_busy_M = busy;
      rst = r;
      @(negedge clk);
      lu = pipe[0].w && pipe[0].ld && (pipe[0].d == a || pipe[0].d == b);
      st = busy || (lu && !br);
      fd = br && !busy;
      fe = (br || lu) && !busy;
      o_st = hz.stall_F; o_fd = hz.flush_D; o_fe = hz.flush_E;
      o_fa = hz.fwdA_E;  o_fb = hz.fwdB_E;
      chk("stall_F",   hz.stall_F,   st);
      chk("stall_D",   hz.stall_D,   st);
      chk("flush_D",   hz.flush_D,   fd);
      chk("flush_E",   hz.flush_E,   fe);
      chk("fwdA_E",    hz.fwdA_E,    fwd_of(pipe[0].a));
      chk("fwdB_E",    hz.fwdB_E,    fwd_of(pipe[0].b));
      chk("stall_cnt", hz.stall_cnt, m_stall);
      chk("lduse_cnt", hz.lduse_cnt, m_lduse);
      @(posedge clk);
      if (r) model_clear();
      else begin
         if (st && m_stall < CMAX) m_stall++;
         if (lu && !br && !busy && m_lduse < CMAX) m_lduse++;
         if (!busy) begin
            nxt.a = a; nxt.b = b; nxt.d = d; nxt.w = w; nxt.ld = ld;
            if (fe) nxt = '{default: 0};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
         end
      end
      #1;
   endtask

   task automatic nop();
      cyc('0, '0, '0, 0, 0, 0, 0, 0);
   endtask

   // Reset with random inputs; outputs are not checked while state is unknown.
   task automatic rst_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         hz.regAD = M'($urandom); hz.regBD = M'($urandom); hz.regScr_D = M'($urandom);
         hz.regw_D = 1'($urandom); hz.regmem_D = 1'($urandom);
         hz.branch_E = 1'($urandom); hz.mem_busy_M = 1'($urandom);
         rst = 1'b1;
         @(posedge clk);
         #1;
      end
      model_clear();
   endtask

   initial begin
      hz.regAD = '0; hz.regBD = '0; hz.regScr_D = '0; hz.regw_D = 0;
      hz.regmem_D = 0; hz.branch_E = 0; hz.mem_busy_M = 0; rst = 1'b1;
      model_clear();

      // 1. reset
      rst_cycles(2);
      cyc(M'($urandom), M'($urandom), M'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
      chk("rst_stall",  o_st, 0);
      chk("rst_flushD", o_fd, 0);
      chk("rst_flushE", o_fe, 0);
      chk("rst_fwdA",   o_fa, 0);
      chk("rst_fwdB",   o_fb, 0);

      // 2. ALU forwarding: M then W
      rst_cycles(1);
      cyc(0, 0, 3, 1, 0, 0, 0, 0);
      cyc(3, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 3, 0, 0, 0, 0, 0, 0);
      chk("alu_fwdA_M",  o_fa, 2'b10);
      chk("alu_nostall", o_st, 0);
      nop();
      chk("alu_fwdB_W",  o_fb, 2'b01);
      chk("alu_stallcnt", hz.stall_cnt, 0);

      // 3. load-use bubble
      rst_cycles(1);
      cyc(0, 0, 5, 1, 1, 0, 0, 0);
      cyc(0, 5, 0, 0, 0, 0, 0, 0);
      chk("lu_stall",  o_st, 1);
      chk("lu_flushE", o_fe, 1);
      chk("lu_flushD", o_fd, 0);
      cyc(0, 5, 0, 0, 0, 0, 0, 0);
      chk("lu_release", o_st, 0);
      chk("lu_noflush", o_fe, 0);
      nop();
      chk("lu_fwdB_W",  o_fb, 2'b01);
      chk("lu_lducnt",  hz.lduse_cnt, 1);
      chk("lu_stlcnt",  hz.stall_cnt, 1);

      // 4. memory wait on top of the load-use bubble
      rst_cycles(1);
      cyc(0, 0, 5, 1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 5, 0, 0, 0, 0, 1, 0);
         chk("mw_stall",  o_st, 1);
         chk("mw_flushE", o_fe, 0);
         chk("mw_flushD", o_fd, 0);
         chk("mw_fwdB",   o_fb, 2'b00);
      end
      cyc(0, 5, 0, 0, 0, 0, 0, 0);
      chk("mw_bubble", o_fe, 1);
      cyc(0, 5, 0, 0, 0, 0, 0, 0);
      chk("mw_release", o_st, 0);
      nop();
      chk("mw_fwdB_W", o_fb, 2'b01);
      chk("mw_stlcnt", hz.stall_cnt, 4);
      chk("mw_lducnt", hz.lduse_cnt, 1);

      // 5. branch wins over load-use
      rst_cycles(1);
      cyc(0, 0, 5, 1, 1, 0, 0, 0);
      cyc(0, 5, 0, 0, 0, 1, 0, 0);
      chk("br_flushD", o_fd, 1);
      chk("br_flushE", o_fe, 1);
      chk("br_stall",  o_st, 0);
      chk("br_lducnt", hz.lduse_cnt, 0);

      // 6. counter saturation, then reset
      rst_cycles(1);
      for (int k = 0; k < 20; k++)
         cyc(M'($urandom), M'($urandom), M'($urandom), 1'($urandom), 1'($urandom), 0, 1, 0);
      chk("sat_stlcnt", hz.stall_cnt, 15);
      rst_cycles(1);
      chk("sat_rst_stlcnt", hz.stall_cnt, 0);

      // randomized traffic on a small register space to force matches
      rst_cycles(1);
      for (int k = 0; k < 400; k++)
         cyc(M'($urandom_range(0, 3)), M'($urandom_range(0, 3)), M'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 60) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 5-stage processor pipeline. It issues the `flush_E` that clears the decode-execute pipeline register, plus the stall, decode-flush and forwarding selects. It keeps its own shadow copy of the E, M and W stage destination and control state, advanced in lock-step with the datapath pipeline registers. It also keeps saturating performance counters for stall cycles and load-use events.

## Interface
Parameters:
- `M`, default 4: register address width.
- `C`, default 16: performance counter width.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, synchronous and active-high.
- `regAD`, `regBD`  in  M: decode-stage source register addresses.
- `regScr_D`  in  M: decode-stage destination register.
- `regw_D`  in  1: decode-stage instruction writes the register file.
- `regmem_D`  in  1: decode-stage instruction is a load (result from memory).
- `branch_E`  in  1: branch taken, resolved in execute.
- `mem_busy_M`  in  1: data memory wait state; freezes the whole pipeline.
- `stall_F`, `stall_D`  out  1: hold the PC and the fetch-decode register.
- `flush_D`  out  1: clear the fetch-decode register.
- `flush_E`  out  1: clear the decode-execute register.
- `fwdA_E`, `fwdB_E`  out  2: execute-operand select. 00 selects the register file, 01 selects the W result, 10 selects the M result. 11 is never driven.
- `stall_cnt`  out  C: count of cycles with `stall_F`=1.
- `lduse_cnt`  out  C: count of load-use bubbles inserted.

## Operation
Shadow state:
- E stage: `srcA_E`, `srcB_E`, `dst_E`, `regw_E`, `regmem_E`.
- M stage: `dst_M`, `regw_M`.
- W stage: `dst_W`, `regw_W`.

Load-use detection:
- `lduse` = `regw_E` & `regmem_E` & (`dst_E`==`regAD` | `dst_E`==`regBD`).
- Detection is conservative: both sources are always compared, and no register is treated as hardwired.

Output equations, with priority memory wait > branch > load-use:
- `stall_F` = `stall_D` = `mem_busy_M` | (`lduse` & ~`branch_E`).
- `flush_D` = `branch_E` & ~`mem_busy_M`.
- `flush_E` = (`branch_E` | `lduse`) & ~`mem_busy_M`.
- When branch and load-use occur together, both flushes assert and there is no stall, so the redirect wins.

Forwarding, shown for A; B is identical using `srcB_E`:
- 10 if `regw_M` & `dst_M`==`srcA_E`.
- Else 01 if `regw_W` & `dst_W`==`srcA_E`.
- Else 00.
- M takes precedence over W when both match, because M holds the newest value.

Shadow advance, on each rising edge when `rst`=0:
- `mem_busy_M`=1: all shadow stages hold.
- Otherwise: W<=M, M<=E.
- E<=0 if `flush_E`; otherwise E<={`regAD`, `regBD`, `regScr_D`, `regw_D`, `regmem_D`}.

Counters:
- `stall_cnt` increments on cycles with `stall_F`=1.
- `lduse_cnt` increments on cycles with `lduse` & ~`branch_E` & ~`mem_busy_M`.
- Both saturate at 2^C-1 and never wrap.

Reset:
- Synchronous `rst` zeroes all shadow state and both counters.
- Consequently every output is 0 after reset: stalls, flushes, `fwdA_E`=`fwdB_E`=00, counters 0.
- A reset mid-stall or mid-busy discards all in-flight tracking; no stale forward may appear afterwards.

## Timing
- Outputs are combinational from shadow state plus the current decode inputs and `branch_E`/`mem_busy_M`. There is zero-cycle response within the cycle.
- Shadow state and counters update only on the rising `clk` edge.
- A load-use bubble lasts exactly one cycle. On the next edge the load moves to M and E holds zeros, so `lduse` drops; the consumer then enters E one cycle later and takes its operand via 01 (W).
- `mem_busy_M` held for N cycles holds all state for N edges. `stall_F` is high for those N cycles and no flush asserts during them.
- `regw`=0 entries never produce a forward or a load-use stall, regardless of address match.

## Test plan
1. **Reset.** Pulse `rst` for 2 cycles with random inputs. Required: all outputs are 0 on the cycle after deassertion, and counters are 0.
2. **ALU forwarding.** Issue D: `regScr_D`=3, `regw_D`=1, then `regAD`=3, then `regBD`=3. Required: the second instruction sees `fwdA_E`=10 in E; the third sees `fwdB_E`=01 in E; no stall occurs.
3. **Load-use.** Issue D: load r5 (`regw_D`=`regmem_D`=1), then `regBD`=5. Required: `stall_F`=`stall_D`=`flush_E`=1 for exactly 1 cycle; the next cycle shows `fwdB_E`=01; `lduse_cnt`=1 and `stall_cnt`=1.
4. **Memory wait during load-use.** Repeat scenario 3 with `mem_busy_M`=1 for 3 cycles during the bubble cycle. Required: stall held for 3 cycles with flushes 0 and forwards unchanged, then one bubble; `stall_cnt`=4 and `lduse_cnt`=1.
5. **Branch with load-use.** Assert `branch_E`=1 in the same cycle as a load-use hazard. Required: `flush_D`=`flush_E`=1, `stall_F`=0, and `lduse_cnt` unchanged.
6. **Saturation.** With `C`=4, hold `mem_busy_M`=1 for 20 cycles. Required: `stall_cnt`=15 and no wrap. Then assert `rst`: required `stall_cnt`=0.
